// File: rtl/gauss_inverse_pkg.sv
// Shared definitions for the Gauss-sum inverse decoder: default width and FSM state encoding.
package gauss_inverse_pkg;

  localparam int GI_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    GI_IDLE = 2'd0,
    GI_RUN  = 2'd1,
    GI_DONE = 2'd2
  } gi_state_e;

endpackage

// File: rtl/gauss_inverse_step.sv
// One repeated-subtraction step of the Gauss inverse: compare, subtract, advance k.
module gauss_step #(
  parameter int width = 16
) (
  input  logic [width-1:0] i_rem,
  input  logic [width-1:0] i_k,
  output logic             o_ge,
  output logic [width-1:0] o_rem_next,
  output logic [width-1:0] o_k_next
);

  assign o_ge       = (i_rem >= i_k);
  assign o_rem_next = i_rem - i_k;
  assign o_k_next   = i_k + width'(1);

endmodule

// File: rtl/gauss_inverse.sv
// Finds the largest n with n(n+1)/2 <= S by subtracting 1,2,3,... one step per clock.
// Optional port 'remainder' (S - n(n+1)/2) is present when GAUSS_INVERSE_REMAINDER_EN is defined.
module gauss_inverse
  import gauss_inverse_pkg::*;
#(
  parameter int width = GI_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             preset,
  input  logic [width-1:0] data,
  input  logic             start,
  output logic [width-1:0] result,
  output logic             exact,
  output logic             busy,
  output logic             done
`ifdef GAUSS_INVERSE_REMAINDER_EN
  ,
  output logic [width-1:0] remainder
`endif
);

  gi_state_e        r_state, w_state_nx;
  logic [width-1:0] r_rem, w_rem_nx;
  logic [width-1:0] r_k, w_k_nx;
  logic [width-1:0] r_result, w_result_nx;
  logic             r_exact, w_exact_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [width-1:0] r_remainder, w_remainder_nx;

  logic             w_ge;
  logic [width-1:0] w_rem_sub;
  logic [width-1:0] w_k_inc;

  gauss_step #(.width(width)) u_step (
    .i_rem      (r_rem),
    .i_k        (r_k),
    .o_ge       (w_ge),
    .o_rem_next (w_rem_sub),
    .o_k_next   (w_k_inc)
  );

  always_comb begin
    w_state_nx     = r_state;
    w_rem_nx       = r_rem;
    w_k_nx         = r_k;
    w_result_nx    = r_result;
    w_exact_nx     = r_exact;
    w_busy_nx      = r_busy;
    w_done_nx      = r_done;
    w_remainder_nx = r_remainder;
    case (r_state)
      // DONE restarts exactly like IDLE; start during RUN is deliberately ignored.
      GI_IDLE, GI_DONE: begin
        if (start) begin
          w_rem_nx   = data;
          w_k_nx     = width'(1);
          w_busy_nx  = 1'b1;
          w_done_nx  = 1'b0;
          w_state_nx = GI_RUN;
        end
      end
      GI_RUN: begin
        if (w_ge) begin
          w_rem_nx = w_rem_sub;
          w_k_nx   = w_k_inc;
        end else begin
          w_result_nx    = r_k - width'(1);
          w_exact_nx     = (r_rem == '0);
          w_remainder_nx = r_rem;
          w_busy_nx      = 1'b0;
          w_done_nx      = 1'b1;
          w_state_nx     = GI_DONE;
        end
      end
      default: w_state_nx = GI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      r_state     <= GI_IDLE;
      r_rem       <= '0;
      r_k         <= '0;
      r_result    <= '0;
      r_exact     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_remainder <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_rem       <= w_rem_nx;
      r_k         <= w_k_nx;
      r_result    <= w_result_nx;
      r_exact     <= w_exact_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_remainder <= w_remainder_nx;
    end
  end

  assign result = r_result;
  assign exact  = r_exact;
  assign busy   = r_busy;
  assign done   = r_done;

`ifdef GAUSS_INVERSE_REMAINDER_EN
  assign remainder = r_remainder;
`else
  // Final remainder is only exported when the optional port exists.
  logic w_unused_remainder;
  assign w_unused_remainder = ^r_remainder;
`endif

endmodule
